// File: rtl/bus_pkg.sv
// Shared types and constants for the 8-bit data / 20-bit address CPU bus master.
// The optional wait-state timeout in bus_cycle_master is enabled by WAIT_TIMEOUT_EN.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    TW   = 3'd4,
    T4   = 3'd5
  } bus_state_t;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 8;

  localparam logic IOM_MEM = 1'b0;
  localparam logic IOM_IO  = 1'b1;

endpackage

// File: rtl/bus_wait_timer.sv
// Counts consecutive TW cycles of one bus cycle and flags the cycle that
// reaches MAX_WAIT, so the master can abort a responder that never goes ready.
module bus_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expired
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] r_cnt;
  logic          w_expired;

  // The current TW is the MAX_WAIT-th one when MAX_WAIT-1 TWs already elapsed.
  assign w_expired = (r_cnt == CW'(MAX_WAIT - 1));
  assign o_expired = w_expired;

  // Wait counter: cleared at the start of each cycle, saturates at the limit.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && !w_expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/bus_cycle_master.sv
// Bus cycle master: converts core read/write requests into T1-T2-T3-[TW]-T4
// bus cycles with ALE/RD/WR/IOM/DEN/DTR strobes and a tri-state data bus.
// Optional feature: define WAIT_TIMEOUT_EN to abort cycles stuck in TW for
// MAX_WAIT clocks (rsp_err=1, read data forced to all ones).
module bus_cycle_master
  import bus_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_io,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ALE,
  output logic              RD,
  output logic              WR,
  output logic              IOM,
  output logic [ADDR_W-1:0] Address,
  inout  wire  [DATA_W-1:0] Data,
  input  logic              READY,
  output logic              DEN,
  output logic              DTR
);

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("bus_cycle_master: MAX_WAIT must be in 1..255");
  end

  bus_state_t        r_state;
  bus_state_t        w_next;
  logic              w_accept;
  logic              w_timeout;
  logic              w_expired;
  logic              w_strobe_ph;
  logic              w_data_ph;

  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic [ADDR_W-1:0] r_addr;
  logic              r_iom;
  logic              r_dtr;
  logic              r_ale;
  logic              r_rd_n;
  logic              r_wr_n;
  logic              r_den_n;
  logic              r_dout_en;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;

  assign req_ready = ((r_state == IDLE) || (r_state == T4)) && !RESET;
  assign w_accept  = req_valid && req_ready;

`ifdef WAIT_TIMEOUT_EN
  logic r_rsp_err;

  bus_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .i_clk     (CLK),
    .i_rst     (RESET),
    .i_clear   (r_state == T2),
    .i_inc     ((r_state == TW) && !READY),
    .o_expired (w_expired)
  );

  // Error flag accompanies the T4 of a cycle forced out of TW.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rsp_err <= 1'b0;
    end else begin
      r_rsp_err <= (w_next == T4) && w_timeout;
    end
  end

  assign rsp_err = r_rsp_err;
`else
  assign w_expired = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; READY is sampled only in T3/TW.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: if (w_accept) w_next = T1;
      T1:   w_next = T2;
      T2:   w_next = T3;
      T3:   w_next = READY ? T4 : TW;
      TW: begin
        if (READY) begin
          w_next = T4;
        end else if (w_expired) begin
          w_next    = T4;
          w_timeout = 1'b1;
        end
      end
      T4:      w_next = w_accept ? T1 : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Strobe phase is T2..TW; data phase extends through T4.
  assign w_strobe_ph = (w_next == T2) || (w_next == T3) || (w_next == TW);
  assign w_data_ph   = w_strobe_ph || (w_next == T4);

  // Request latch: write data is pure datapath and carries no reset.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_wdata <= req_wdata;
    end
  end

  // Registered bus outputs, decoded from the state being entered.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_iom       <= IOM_MEM;
      r_dtr       <= 1'b0;
      r_ale       <= 1'b0;
      r_rd_n      <= 1'b1;
      r_wr_n      <= 1'b1;
      r_den_n     <= 1'b1;
      r_dout_en   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_iom   <= req_io ? IOM_IO : IOM_MEM;
        r_dtr   <= req_write;
      end
      r_ale       <= (w_next == T1);
      r_rd_n      <= !(w_strobe_ph && !r_write);
      r_wr_n      <= !(w_strobe_ph && r_write);
      r_den_n     <= !w_data_ph;
      r_dout_en   <= w_data_ph && r_write;
      r_rsp_valid <= (w_next == T4);
      if (((r_state == T3) || (r_state == TW)) && (w_next == T4) && !r_write) begin
        r_rsp_rdata <= w_timeout ? '1 : Data;
      end
    end
  end

  assign ALE       = r_ale;
  assign RD        = r_rd_n;
  assign WR        = r_wr_n;
  assign IOM       = r_iom;
  assign Address   = r_addr;
  assign DEN       = r_den_n;
  assign DTR       = r_dtr;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign Data      = r_dout_en ? r_wdata : 'z;

endmodule

// File: tb/tb_bus_cycle_master.sv
// Directed bench for bus_cycle_master: a per-cycle vector table covering read,
// write, wait states and back-to-back cycles, plus hand-written sequences for
// mid-cycle reset and the stuck-READY case (timeout or indefinite wait).
module tb_bus_cycle_master;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_io;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        ALE, RD, WR, IOM, DEN, DTR;
  logic [19:0] Address;
  wire  [7:0]  Data;
  logic        READY;
  logic        tb_drv;
  logic [7:0]  tb_dv;

  int n_chk = 0;
  int n_err = 0;

  assign Data = tb_drv ? tb_dv : 'z;

  always #5 CLK = ~CLK;

  bus_cycle_master #(
    .ADDR_W   (20),
    .DATA_W   (8),
    .MAX_WAIT (15)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_io    (req_io),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ALE       (ALE),
    .RD        (RD),
    .WR        (WR),
    .IOM       (IOM),
    .Address   (Address),
    .Data      (Data),
    .READY     (READY),
    .DEN       (DEN),
    .DTR       (DTR)
  );

  typedef struct {
    logic        rv, wr, io;
    logic [19:0] addr;
    logic [7:0]  wd;
    logic        rdy, drv;
    logic [7:0]  dv;
    logic        ale, rd, wrn, den, dtr, iom, vld, rreq;
    logic [19:0] ea;
    logic [7:0]  erd;
    logic        crd, cd;
    logic [7:0]  ed;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic rv, wr, io, input logic [19:0] addr, input logic [7:0] wd,
    input logic rdy, drv, input logic [7:0] dv,
    input logic ale, rd, wrn, den, dtr, iom, vld, rreq,
    input logic [19:0] ea, input logic [7:0] erd, input logic crd, cd,
    input logic [7:0] ed);
    vec_t v;
    v.rv = rv; v.wr = wr; v.io = io; v.addr = addr; v.wd = wd;
    v.rdy = rdy; v.drv = drv; v.dv = dv;
    v.ale = ale; v.rd = rd; v.wrn = wrn; v.den = den; v.dtr = dtr; v.iom = iom;
    v.vld = vld; v.rreq = rreq; v.ea = ea; v.erd = erd; v.crd = crd; v.cd = cd;
    v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input logic rv, input logic wr, input logic io,
                         input logic [19:0] a, input logic [7:0] wd);
    req_valid = rv; req_write = wr; req_io = io; req_addr = a; req_wdata = wd;
  endtask

  initial begin
    int n;
    int pulses;

    // rv wr io addr wd rdy drv dv | ale rd wr den dtr iom vld rreq ea erd crd cd ed
    // Read memory 0x12345, responder returns 0xA5
    tbl[0]  = mk(1,0,0,20'h12345,8'h00,1,0,8'h00, 1,1,1,1,0,0,0,0,20'h12345,8'h00,0,0,8'h00);
    tbl[1]  = mk(0,0,0,20'h12345,8'h00,1,1,8'hA5, 0,0,1,0,0,0,0,0,20'h12345,8'h00,0,1,8'hA5);
    tbl[2]  = mk(0,0,0,20'h12345,8'h00,1,1,8'hA5, 0,0,1,0,0,0,0,0,20'h12345,8'h00,0,1,8'hA5);
    tbl[3]  = mk(0,0,0,20'h12345,8'h00,1,1,8'hA5, 0,1,1,0,0,0,1,1,20'h12345,8'hA5,1,1,8'hA5);
    tbl[4]  = mk(0,0,0,20'h12345,8'h00,1,0,8'h00, 0,1,1,1,0,0,0,1,20'h12345,8'h00,0,0,8'h00);
    // Write IO 0x003F8 data 0x5C
    tbl[5]  = mk(1,1,1,20'h003F8,8'h5C,1,0,8'h00, 1,1,1,1,1,1,0,0,20'h003F8,8'h00,0,0,8'h00);
    tbl[6]  = mk(0,1,1,20'h003F8,8'h5C,1,0,8'h00, 0,1,0,0,1,1,0,0,20'h003F8,8'h00,0,1,8'h5C);
    tbl[7]  = mk(0,1,1,20'h003F8,8'h5C,1,0,8'h00, 0,1,0,0,1,1,0,0,20'h003F8,8'h00,0,1,8'h5C);
    tbl[8]  = mk(0,1,1,20'h003F8,8'h5C,1,0,8'h00, 0,1,1,0,1,1,1,1,20'h003F8,8'h00,0,1,8'h5C);
    tbl[9]  = mk(0,1,1,20'h003F8,8'h5C,1,0,8'h00, 0,1,1,1,1,1,0,1,20'h003F8,8'h00,0,0,8'h00);
    // Read 0x00ABC with READY low for T3 and two TWs (three TW inserted)
    tbl[10] = mk(1,0,0,20'h00ABC,8'h00,1,0,8'h00, 1,1,1,1,0,0,0,0,20'h00ABC,8'h00,0,0,8'h00);
    tbl[11] = mk(0,0,0,20'h00ABC,8'h00,1,1,8'h3C, 0,0,1,0,0,0,0,0,20'h00ABC,8'h00,0,1,8'h3C);
    tbl[12] = mk(0,0,0,20'h00ABC,8'h00,1,1,8'h3C, 0,0,1,0,0,0,0,0,20'h00ABC,8'h00,0,1,8'h3C);
    tbl[13] = mk(0,0,0,20'h00ABC,8'h00,0,1,8'h3C, 0,0,1,0,0,0,0,0,20'h00ABC,8'h00,0,1,8'h3C);
    tbl[14] = mk(0,0,0,20'h00ABC,8'h00,0,1,8'h3C, 0,0,1,0,0,0,0,0,20'h00ABC,8'h00,0,1,8'h3C);
    tbl[15] = mk(0,0,0,20'h00ABC,8'h00,0,1,8'h3C, 0,0,1,0,0,0,0,0,20'h00ABC,8'h00,0,1,8'h3C);
    tbl[16] = mk(0,0,0,20'h00ABC,8'h00,1,1,8'h3C, 0,1,1,0,0,0,1,1,20'h00ABC,8'h3C,1,1,8'h3C);
    tbl[17] = mk(0,0,0,20'h00ABC,8'h00,1,0,8'h00, 0,1,1,1,0,0,0,1,20'h00ABC,8'h00,0,0,8'h00);
    // Back-to-back: read 0x00010 then write 0x00011 (0x77) held until accepted
    tbl[18] = mk(1,0,0,20'h00010,8'h00,1,0,8'h00, 1,1,1,1,0,0,0,0,20'h00010,8'h00,0,0,8'h00);
    tbl[19] = mk(1,1,0,20'h00011,8'h77,1,1,8'h96, 0,0,1,0,0,0,0,0,20'h00010,8'h00,0,1,8'h96);
    tbl[20] = mk(1,1,0,20'h00011,8'h77,1,1,8'h96, 0,0,1,0,0,0,0,0,20'h00010,8'h00,0,1,8'h96);
    tbl[21] = mk(1,1,0,20'h00011,8'h77,1,1,8'h96, 0,1,1,0,0,0,1,1,20'h00010,8'h96,1,1,8'h96);
    tbl[22] = mk(1,1,0,20'h00011,8'h77,1,0,8'h00, 1,1,1,1,1,0,0,0,20'h00011,8'h00,0,0,8'h00);
    tbl[23] = mk(0,1,0,20'h00011,8'h77,1,0,8'h00, 0,1,0,0,1,0,0,0,20'h00011,8'h00,0,1,8'h77);
    tbl[24] = mk(0,1,0,20'h00011,8'h77,1,0,8'h00, 0,1,0,0,1,0,0,0,20'h00011,8'h00,0,1,8'h77);
    tbl[25] = mk(0,1,0,20'h00011,8'h77,1,0,8'h00, 0,1,1,0,1,0,1,1,20'h00011,8'h00,0,1,8'h77);
    tbl[26] = mk(0,1,0,20'h00011,8'h77,1,0,8'h00, 0,1,1,1,1,0,0,1,20'h00011,8'h00,0,0,8'h00);

    RESET = 1'b1; READY = 1'b1; tb_drv = 1'b0; tb_dv = 8'h00;
    set_req(0, 0, 0, 20'h0, 8'h0);

    // Reset state
    step(); step();
    chk("rst ALE", ALE, 0);
    chk("rst RD", RD, 1);
    chk("rst WR", WR, 1);
    chk("rst DEN", DEN, 1);
    chk("rst DTR", DTR, 0);
    chk("rst IOM", IOM, 0);
    chk("rst Address", Address, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_rdata", rsp_rdata, 0);
    chk("rst rsp_err", rsp_err, 0);
    chk("rst req_ready", req_ready, 0);
    RESET = 1'b0;
    #1;
    chk("idle req_ready", req_ready, 1);

    // Vector table
    for (int i = 0; i < NV; i++) begin
      set_req(tbl[i].rv, tbl[i].wr, tbl[i].io, tbl[i].addr, tbl[i].wd);
      READY = tbl[i].rdy; tb_drv = tbl[i].drv; tb_dv = tbl[i].dv;
      step();
      chk($sformatf("row%0d ALE", i), ALE, tbl[i].ale);
      chk($sformatf("row%0d RD", i), RD, tbl[i].rd);
      chk($sformatf("row%0d WR", i), WR, tbl[i].wrn);
      chk($sformatf("row%0d DEN", i), DEN, tbl[i].den);
      chk($sformatf("row%0d DTR", i), DTR, tbl[i].dtr);
      chk($sformatf("row%0d IOM", i), IOM, tbl[i].iom);
      chk($sformatf("row%0d rsp_valid", i), rsp_valid, tbl[i].vld);
      chk($sformatf("row%0d req_ready", i), req_ready, tbl[i].rreq);
      chk($sformatf("row%0d Address", i), Address, tbl[i].ea);
      chk($sformatf("row%0d rsp_err", i), rsp_err, 0);
      if (tbl[i].crd) chk($sformatf("row%0d rsp_rdata", i), rsp_rdata, tbl[i].erd);
      if (tbl[i].cd)  chk($sformatf("row%0d Data", i), Data, tbl[i].ed);
    end

    // Reset during TW: bus returns to idle values, aborted cycle gives no response
    set_req(1, 0, 1, 20'h00100, 8'h00); READY = 1'b0; tb_drv = 1'b0;
    step();
    set_req(0, 0, 0, 20'h00100, 8'h00);
    step(); step(); step(); step();
    chk("tw RD low", RD, 0);
    chk("tw DEN low", DEN, 0);
    RESET = 1'b1;
    #1;
    chk("reset req_ready", req_ready, 0);
    step();
    chk("abort ALE", ALE, 0);
    chk("abort RD", RD, 1);
    chk("abort WR", WR, 1);
    chk("abort DEN", DEN, 1);
    chk("abort IOM", IOM, 0);
    chk("abort Address", Address, 0);
    chk("abort rsp_valid", rsp_valid, 0);
    RESET = 1'b0; READY = 1'b1;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (rsp_valid) pulses++;
    end
    chk("abort no rsp pulses", pulses, 0);
    tb_drv = 1'b1; tb_dv = 8'hC3;
    #1;
    chk("idle Data released", Data, 8'hC3);

    // Normal read after reset: response on the 4th clock after accept
    tb_dv = 8'h5A;
    set_req(1, 0, 0, 20'h00200, 8'h00);
    n = 0;
    do begin
      step();
      n++;
      req_valid = 1'b0;
    end while (!rsp_valid && n < 20);
    chk("post-reset latency", n, 4);
    chk("post-reset rdata", rsp_rdata, 8'h5A);
    chk("post-reset Address", Address, 20'h00200);
    tb_drv = 1'b0;
    step();

`ifdef WAIT_TIMEOUT_EN
    // READY stuck low: 15 TW then forced T4 with error and all-ones data
    READY = 1'b0;
    set_req(1, 0, 0, 20'h00300, 8'h00);
    n = 0;
    do begin
      step();
      n++;
      req_valid = 1'b0;
    end while (!rsp_valid && n < 40);
    chk("timeout latency", n, 19);
    chk("timeout rsp_err", rsp_err, 1);
    chk("timeout rdata", rsp_rdata, 8'hFF);
    chk("timeout RD released", RD, 1);
    step();
    chk("timeout err clears", rsp_err, 0);
    READY = 1'b1;
`else
    // READY stuck low: the cycle waits indefinitely with no response
    READY = 1'b0;
    set_req(1, 0, 0, 20'h00300, 8'h00);
    step();
    req_valid = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (rsp_valid) pulses++;
    end
    chk("stuck no rsp", pulses, 0);
    chk("stuck RD held", RD, 0);
    chk("stuck rsp_err", rsp_err, 0);
    READY = 1'b1;
    step();
    chk("stuck release rsp_valid", rsp_valid, 1);
    chk("stuck release rsp_err", rsp_err, 0);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
